sample_packer: RTL and testbench
================================

# sample_packer

Downstream stage of the test-pattern sample generator: it consumes the generator's 16-bit sample stream and its frame sync. It packs sample pairs into 32-bit words and inserts a header word at the start of every frame. The words are buffered in a small show-ahead FIFO and presented on a valid/ready interface to the USB3 FIFO write logic. A full FIFO drops words and sets a sticky overflow flag; it never stalls the generator.

## Interface
Parameters:
- FIFO_DEPTH, 16: FIFO depth in 32-bit words; power of two, minimum 4.
- HEADER_TAG, 16'hA5A5: upper half of every header word.

Ports:
- clk_i  input  1  single clock for the whole block; all logic on rising edge.
- reset_i  input  1  reset, asynchronous, active-low.
- framesync_i  input  1  frame sync level, synchronous to clk_i; the rising edge marks frame start.
- byte_i  input  16  sample data.
- byte_valid_i  input  1  byte_i is valid this cycle.
- word_o  output  32  FIFO head word.
- word_valid_o  output  1  FIFO not empty.
- word_ready_i  input  1  consumer accepts word_o this cycle.
- overflow_o  output  1  sticky: at least one word was dropped since reset.
- frame_count_o  output  16  number of frame headers generated, modulo 2^16.

## Operation
- Edge detect: fs_q is the registered framesync_i and resets to 1. A frame-start edge (fs_edge) is framesync_i=1 while fs_q=0. Because fs_q resets to 1, framesync_i held high through reset release produces no header.
- Packer phase: phase=0 expects the low half, phase=1 expects the high half.
  - On byte_valid_i with phase=0: hold[15:0] <= byte_i, phase <= 1.
  - On byte_valid_i with phase=1: push {byte_i, hold[15:0]}, phase <= 0.
- On fs_edge:
  - Push header {HEADER_TAG, frame_count_o}, then frame_count_o <= frame_count_o+1, wrapping 16'hFFFF -> 0.
  - Any pending low half is discarded.
  - If byte_valid_i is also high that cycle, byte_i becomes the low half of the new frame: hold <= byte_i, phase <= 1. Otherwise phase <= 0.
  - At most one push therefore occurs per cycle.
- FIFO:
  - Circular buffer, FIFO_DEPTH entries; pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits.
  - pop = word_valid_o && word_ready_i.
  - A push is accepted when occupancy < FIFO_DEPTH, or when the FIFO is full and pop is high in the same cycle.
  - A rejected push (header or data) is dropped and sets overflow_o <= 1, held until reset.
  - Simultaneous accepted push and pop leaves occupancy unchanged.
- Output: word_valid_o = (occupancy != 0). word_o is the memory at the read pointer (show-ahead); its value is don't-care while word_valid_o=0. word_ready_i is ignored while word_valid_o=0.
- Reset (async assert, sync deassert handled upstream) forces:
  - word_valid_o=0, word_o=0, overflow_o=0, frame_count_o=0;
  - phase=0, hold=0, fs_q=1, pointers and occupancy 0.
- Reset mid-frame discards all buffered words and any partial pair.

## Timing
- Data latency: a pair completing at cycle N into an empty FIFO gives word_valid_o=1 with word_o={second,first} at cycle N+1.
- Header latency: fs_edge at cycle N into an empty FIFO gives the header on word_o at N+1, and frame_count_o increments at N+1.
- A pop at cycle N advances word_o to the next entry at N+1.
- Throughput: the consumer drains 1 word/cycle; the producer generates at most 1 word per 2 valid samples, plus 1 header per frame.
- overflow_o rises the cycle after the first rejected push.
- No combinational path from word_ready_i to word_valid_o or word_o.

## Test plan
- Reset/idle: hold reset_i=0 with framesync_i=1, then release. Required: all outputs 0 and no header word at any point.
- Basic frame: framesync_i edge, then samples 16'h0001..16'h0004 on consecutive cycles, word_ready_i=1. Required sequence:
  - 32'hA5A5_0000
  - 32'h0002_0001
  - 32'h0004_0003
  - frame_count_o=1.
- Partial pair discard: edge, samples 16'h1111, 16'h2222, 16'h3333, then a second edge coinciding with sample 16'h4444, then 16'h5555. Required sequence:
  - 32'hA5A5_0000
  - 32'h2222_1111
  - 32'hA5A5_0001
  - 32'h5555_4444
- Backpressure/overflow: FIFO_DEPTH=16, word_ready_i=0, edge plus 40 samples. Required: 16 words retained (header plus the first 15 pairs), overflow_o=1. After draining, words appear in order and overflow_o stays 1.
- Full with simultaneous pop: fill the FIFO to exactly 16 words, then complete a pair in the same cycle as a pop. Required: the word is accepted, occupancy stays 16, overflow_o stays 0.
- Frame counter wrap: 65537 frame edges. Required: the header after 16'hFFFF carries 32'hA5A5_FFFF, the next carries 32'hA5A5_0000, and frame_count_o reads 1 at the end.

Source files
------------

// File: rtl/sample_packer.sv
// sample_packer: packs 16-bit sample pairs into 32-bit words, inserts a
// {HEADER_TAG, frame_count} header at each frame-sync rising edge and
// buffers everything in a show-ahead FIFO. Words that do not fit are
// dropped and flagged on the sticky overflow output; the producer is never
// stalled.
module sample_packer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] HEADER_TAG = 16'hA5A5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        framesync_i,
    input  logic [15:0] byte_i,
    input  logic        byte_valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        overflow_o,
    output logic [15:0] frame_count_o
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;

    phase_e        phase_q, phase_d;
    logic [15:0]   hold_q, hold_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          fs_q;
    logic          overflow_q, overflow_d;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    logic          fs_edge;
    logic          push_req;
    logic [31:0]   push_data;
    logic          pop;
    logic          full;
    logic          push_ok;

    assign fs_edge = framesync_i & ~fs_q;

    // Packer: header on frame edge, otherwise pair low/high halves into a word.
    always_comb begin
        phase_d     = phase_q;
        hold_d      = hold_q;
        frame_cnt_d = frame_cnt_q;
        push_req    = 1'b0;
        push_data   = '0;
        if (fs_edge) begin
            push_req    = 1'b1;
            push_data   = {HEADER_TAG, frame_cnt_q};
            frame_cnt_d = frame_cnt_q + 16'd1;
            // A pending low half is dropped; a coincident sample opens the new frame.
            if (byte_valid_i) begin
                hold_d  = byte_i;
                phase_d = PH_HI;
            end else begin
                phase_d = PH_LO;
            end
        end else if (byte_valid_i) begin
            case (phase_q)
                PH_LO: begin
                    hold_d  = byte_i;
                    phase_d = PH_HI;
                end
                PH_HI: begin
                    push_req  = 1'b1;
                    push_data = {byte_i, hold_q};
                    phase_d   = PH_LO;
                end
                default: phase_d = PH_LO;
            endcase
        end
    end

    // FIFO control: a push into a full FIFO is only accepted alongside a pop.
    always_comb begin
        pop        = (count_q != '0) && word_ready_i;
        full       = (count_q == DEPTH_C);
        push_ok    = push_req && (!full || pop);
        overflow_d = overflow_q | (push_req & ~push_ok);
        wptr_d     = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
        count_d    = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            phase_q     <= PH_LO;
            hold_q      <= '0;
            frame_cnt_q <= '0;
            fs_q        <= 1'b1;
            overflow_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            frame_cnt_q <= frame_cnt_d;
            fs_q        <= framesync_i;
            overflow_q  <= overflow_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates output.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    // Head word is forced to zero while empty so reset presents word_o=0.
    assign word_valid_o  = (count_q != '0);
    assign word_o        = word_valid_o ? mem_q[rptr_q] : '0;
    assign overflow_o    = overflow_q;
    assign frame_count_o = frame_cnt_q;

endmodule

// File: tb/tb_sample_packer.sv
// Testbench for sample_packer: a frame/pair reference model feeds an
// expected-word queue; a monitor compares every handshake and the status
// outputs on the falling edge.
module tb_sample_packer;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        fs;
    logic [15:0] smp;
    logic        smp_v;
    logic [31:0] word;
    logic        word_v;
    logic        rdy;
    logic        ovf;
    logic [15:0] fcnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state
    logic [31:0] exp_q [$];
    logic [31:0] seen_q [$];
    bit          m_fs_prev = 1'b1;
    bit          m_pending = 1'b0;
    logic [15:0] m_low = '0;
    logic [15:0] m_frames = '0;
    bit          m_ovf = 1'b0;

    sample_packer #(
        .FIFO_DEPTH (DEPTH),
        .HEADER_TAG (16'hA5A5)
    ) dut (
        .clk_i         (clk),
        .reset_i       (rst_n),
        .framesync_i   (fs),
        .byte_i        (smp),
        .byte_valid_i  (smp_v),
        .word_o        (word),
        .word_valid_o  (word_v),
        .word_ready_i  (rdy),
        .overflow_o    (ovf),
        .frame_count_o (fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_fs_prev = 1'b1;
        m_pending = 1'b0;
        m_low     = '0;
        m_frames  = '0;
        m_ovf     = 1'b0;
    endtask

    task automatic model_push(input logic [31:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    // Applied after the monitor has already removed this cycle's popped word,
    // so "size < DEPTH" covers both free space and full-with-pop.
    task automatic model_apply();
        if (fs && !m_fs_prev) begin
            model_push({16'hA5A5, m_frames});
            m_frames  = m_frames + 16'd1;
            m_pending = smp_v;
            if (smp_v) m_low = smp;
        end else if (smp_v) begin
            if (m_pending) begin
                model_push({smp, m_low});
                m_pending = 1'b0;
            end else begin
                m_pending = 1'b1;
                m_low     = smp;
            end
        end
        m_fs_prev = fs;
    endtask

    task automatic cycle(input bit f, input bit v, input logic [15:0] d, input bit r);
        @(posedge clk);
        #1;
        fs = f; smp_v = v; smp = d; rdy = r;
        if (!rst_n) model_reset();
        @(negedge clk);
        #1;
        if (rst_n) model_apply();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic check_seen(input string name, input logic [31:0] want [$]);
        chk({name, "_count"}, 32'(seen_q.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < seen_q.size(); i++) begin
            chk($sformatf("%s_word%0d", name, i), seen_q[i], want[i]);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            chk("word_valid", {31'b0, word_v}, {31'b0, (exp_q.size() != 0)});
            chk("frame_count", {16'b0, fcnt}, {16'b0, m_frames});
            chk("overflow", {31'b0, ovf}, {31'b0, m_ovf});
            if (!rst_n) chk("reset_word", word, 32'h0);
            if (rst_n && rdy && exp_q.size() != 0) begin
                chk("word", word, exp_q[0]);
                seen_q.push_back(word);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] want [$];
        logic [15:0] lo;
        rst_n = 1'b0; fs = 1'b1; smp = '0; smp_v = 1'b0; rdy = 1'b1;

        // Reset with framesync held high: no header after release
        repeat (4) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        chk("idle_valid", {31'b0, word_v}, 32'h0);
        chk("idle_frames", {16'b0, fcnt}, 32'h0);
        chk("idle_seen", 32'(seen_q.size()), 32'h0);

        // Basic frame
        do_reset();
        seen_q.delete();
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 16'(i), 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        want = '{32'hA5A5_0000, 32'h0002_0001, 32'h0004_0003};
        check_seen("basic", want);
        chk("basic_frames", {16'b0, fcnt}, 32'h1);

        // Partial pair discard with edge coinciding with a sample
        do_reset();
        seen_q.delete();
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b1, 16'h1111, 1'b1);
        cycle(1'b1, 1'b1, 16'h2222, 1'b1);
        cycle(1'b1, 1'b1, 16'h3333, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b1, 16'h4444, 1'b1);
        cycle(1'b1, 1'b1, 16'h5555, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        want = '{32'hA5A5_0000, 32'h2222_1111, 32'hA5A5_0001, 32'h5555_4444};
        check_seen("partial", want);

        // Backpressure and overflow
        do_reset();
        seen_q.delete();
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 40; i++) cycle(1'b1, 1'b1, 16'(i), 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        chk("ovf_set", {31'b0, ovf}, 32'h1);
        repeat (20) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        want.delete();
        want.push_back(32'hA5A5_0000);
        for (int k = 1; k <= 15; k++) want.push_back({16'(2*k), 16'(2*k-1)});
        check_seen("overflow_drain", want);
        chk("ovf_sticky", {31'b0, ovf}, 32'h1);

        // Full FIFO with a pair completing in the same cycle as a pop
        do_reset();
        seen_q.delete();
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 1; i <= 30; i++) cycle(1'b1, 1'b1, 16'(16'h0100 + i), 1'b0);
        cycle(1'b1, 1'b1, 16'hBEE0, 1'b0);
        cycle(1'b1, 1'b1, 16'hBEE1, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        chk("fullpop_ovf", {31'b0, ovf}, 32'h0);
        repeat (20) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        chk("fullpop_count", 32'(seen_q.size()), 32'd17);
        if (seen_q.size() == 17) chk("fullpop_last", seen_q[16], 32'hBEE1_BEE0);
        chk("fullpop_ovf_end", {31'b0, ovf}, 32'h0);

        // Randomized traffic
        do_reset();
        fs = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit f, v, r;
            f = ($urandom_range(0, 19) == 0) ? ~fs : fs;
            v = ($urandom_range(0, 9) < 7);
            r = (n % 400 < 100) ? 1'b0 : ($urandom_range(0, 1) == 1);
            lo = 16'($urandom);
            cycle(f, v, lo, r);
        end
        repeat (40) cycle(1'b0, 1'b0, 16'h0, 1'b1);

        // Frame counter wrap (counter preloaded near the top)
        do_reset();
        seen_q.delete();
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        force dut.frame_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.frame_cnt_q;
        m_frames = 16'hFFFE;
        for (int e = 0; e < 3; e++) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b1);
            cycle(1'b0, 1'b0, 16'h0, 1'b1);
        end
        repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b1);
        want = '{32'hA5A5_FFFE, 32'hA5A5_FFFF, 32'hA5A5_0000};
        check_seen("wrap", want);
        chk("wrap_frames", {16'b0, fcnt}, 32'h1);

        chk("leftover_expected", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
